// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer.
//   EXC_SYS / EXC_BP : ExcCode values for SYSCALL and BREAK.
//   HANDLER_VEC_DEF  : default exception handler entry address.
//   exc_state_t      : sequencer state encoding.
package exc_ctrl_pkg;

  localparam logic [5:0]  EXC_SYS         = 6'd8;
  localparam logic [5:0]  EXC_BP          = 6'd9;
  localparam logic [31:0] HANDLER_VEC_DEF = 32'h8000_0180;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_FLUSH,
    ST_HANDLER,
    ST_RETURN
  } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for MEM-stage trap requests.
// Priority is syscall > break > trap; lower-priority requests are dropped.
//   syscall_req, break_req, trap_req : request lines
//   trap_cause                       : ExcCode used for trap_req
//   req_valid                        : any request present
//   req_code                         : ExcCode of the winning request
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       syscall_req,
  input  logic       break_req,
  input  logic       trap_req,
  input  logic [5:0] trap_cause,
  output logic       req_valid,
  output logic [5:0] req_code
);

  always_comb begin
    req_valid = syscall_req | break_req | trap_req;
    req_code  = '0;
    if (syscall_req)
      req_code = EXC_SYS;
    else if (break_req)
      req_code = EXC_BP;
    else if (trap_req)
      req_code = trap_cause;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer between trap detection and the CP0 register block.
// Commits one exception at a time to CP0, flushes the pipeline, redirects
// the PC to the handler, tracks EXL and sequences ERET back to EPC.
//   clk, rst (async, active-low)
//   syscall_req/break_req/trap_req/trap_cause/trap_pc : MEM-stage trap requests
//   eret_req, epc_i                                   : ERET request and CP0 EPC
//   syscall_o/break_o/eret_o/cause_o/epc_o            : CP0 commit interface
//   flush_o, redirect_valid, redirect_pc              : pipeline control
//   exl_o, busy_o, double_fault_o                     : status
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC  = HANDLER_VEC_DEF,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        trap_req,
  input  logic [5:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        eret_req,
  input  logic [31:0] epc_i,
  output logic        syscall_o,
  output logic        break_o,
  output logic [5:0]  cause_o,
  output logic [31:0] epc_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exl_o,
  output logic        busy_o,
  output logic        double_fault_o
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  exc_state_t  state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        req_valid;
  logic [5:0]  req_code;

  logic        syscall_n, break_n, eret_n, flush_n, rv_n, exl_n, df_n;
  logic [5:0]  cause_n;
  logic [31:0] epc_n, rpc_n;

  exc_prio_enc u_prio (
    .syscall_req (syscall_req),
    .break_req   (break_req),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .req_valid   (req_valid),
    .req_code    (req_code)
  );

  // Outputs are computed for the state being entered and then registered,
  // so each output value belongs to the cycle spent in state_n.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    syscall_n = 1'b0;
    break_n   = 1'b0;
    eret_n    = 1'b0;
    flush_n   = 1'b0;
    rv_n      = 1'b0;
    exl_n     = 1'b0;
    df_n      = double_fault_o;
    cause_n   = cause_o;
    epc_n     = epc_o;
    rpc_n     = redirect_pc;

    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_n   = ST_COMMIT;
          syscall_n = syscall_req;
          break_n   = ~syscall_req & break_req;
          cause_n   = req_code;
          epc_n     = trap_pc;
          flush_n   = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_n = ST_FLUSH;
        cnt_n   = CNT_LOAD;
        flush_n = 1'b1;
        if (CNT_LOAD == 3'd0) begin
          rv_n  = 1'b1;
          rpc_n = HANDLER_VEC;
        end
      end
      ST_FLUSH: begin
        if (cnt == 3'd0) begin
          state_n = ST_HANDLER;
          exl_n   = 1'b1;
        end else begin
          cnt_n   = cnt - 3'd1;
          flush_n = 1'b1;
          if (cnt == 3'd1) begin
            rv_n  = 1'b1;
            rpc_n = HANDLER_VEC;
          end
        end
      end
      ST_HANDLER: begin
        exl_n = 1'b1;
        // A nested fault beats a simultaneous ERET; CP0 is left untouched
        // so the original EPC survives.
        if (req_valid) begin
          df_n    = 1'b1;
          flush_n = 1'b1;
          rv_n    = 1'b1;
          rpc_n   = HANDLER_VEC;
        end else if (eret_req) begin
          state_n = ST_RETURN;
          eret_n  = 1'b1;
          flush_n = 1'b1;
          rv_n    = 1'b1;
          rpc_n   = epc_i;
        end
      end
      ST_RETURN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      syscall_o      <= 1'b0;
      break_o        <= 1'b0;
      eret_o         <= 1'b0;
      flush_o        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cause_o        <= '0;
      epc_o          <= '0;
      exl_o          <= 1'b0;
      busy_o         <= 1'b0;
      double_fault_o <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      syscall_o      <= syscall_n;
      break_o        <= break_n;
      eret_o         <= eret_n;
      flush_o        <= flush_n;
      redirect_valid <= rv_n;
      redirect_pc    <= rpc_n;
      cause_o        <= cause_n;
      epc_o          <= epc_n;
      exl_o          <= exl_n;
      busy_o         <= (state_n != ST_IDLE);
      double_fault_o <= df_n;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes hand-computed expected
// output snapshots; a monitor pops one whenever the DUT shows an event
// (CP0 pulse, flush or redirect) and compares it.
module tb_exc_ctrl;

  logic        clk, rst;
  logic        syscall_req, break_req, trap_req, eret_req;
  logic [5:0]  trap_cause;
  logic [31:0] trap_pc, epc_i;
  logic        syscall_o, break_o, eret_o, flush_o, redirect_valid;
  logic        exl_o, busy_o, double_fault_o;
  logic [5:0]  cause_o;
  logic [31:0] epc_o, redirect_pc;

  localparam logic [31:0] HV = 32'h8000_0180;

  exc_ctrl #(.HANDLER_VEC(HV), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .syscall_req    (syscall_req),
    .break_req      (break_req),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .eret_req       (eret_req),
    .epc_i          (epc_i),
    .syscall_o      (syscall_o),
    .break_o        (break_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .eret_o         (eret_o),
    .flush_o        (flush_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exl_o          (exl_o),
    .busy_o         (busy_o),
    .double_fault_o (double_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags: {syscall, break, eret, flush, redirect_valid, exl, busy, double_fault}
  typedef struct {
    string       tag;
    logic [7:0]  flags;
    logic [5:0]  cause;
    logic [31:0] epc;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  function automatic exp_t mk(string tag, logic [7:0] flags, logic [5:0] cause,
                              logic [31:0] epc, logic [31:0] rpc);
    exp_t e;
    e.tag = tag; e.flags = flags; e.cause = cause; e.epc = epc; e.rpc = rpc;
    return e;
  endfunction

  function automatic logic [7:0] act_flags();
    return {syscall_o, break_o, eret_o, flush_o, redirect_valid, exl_o, busy_o, double_fault_o};
  endfunction

  // Monitor: pop and compare on every event cycle.
  initial begin
    exp_t e;
    logic [7:0] f;
    forever begin
      @(negedge clk);
      if (syscall_o | break_o | eret_o | flush_o | redirect_valid) begin
        f = act_flags();
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got flags=%b cause=%0d epc=%h rpc=%h, expected no event",
                   f, cause_o, epc_o, redirect_pc);
        end else begin
          e = q.pop_front();
          if (f !== e.flags || cause_o !== e.cause || epc_o !== e.epc ||
              (e.flags[3] && redirect_pc !== e.rpc)) begin
            fails++;
            $display("FAIL %s: got flags=%b cause=%0d epc=%h rpc=%h, expected flags=%b cause=%0d epc=%h rpc=%h",
                     e.tag, f, cause_o, epc_o, redirect_pc, e.flags, e.cause, e.epc, e.rpc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the already-driven request inputs across one capture edge.
  task automatic pulse();
    cycles(1);
    syscall_req = 1'b0; break_req = 1'b0; trap_req = 1'b0; eret_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    syscall_req = 1'b0; break_req = 1'b0; trap_req = 1'b0; eret_req = 1'b0;
    trap_cause = '0; trap_pc = '0; epc_i = '0;

    cycles(2);
    check("reset_flags", 64'(act_flags()), 64'h0);
    check("reset_data", {cause_o[5:0], epc_o, 26'(redirect_pc[25:0])}, 64'h0);
    rst = 1'b1;
    cycles(1);

    // SYSCALL
    q.push_back(mk("sys_commit", 8'b1001_0010, 6'd8, 32'h0040_0020, 32'h0));
    q.push_back(mk("sys_flush1", 8'b0001_0010, 6'd8, 32'h0040_0020, 32'h0));
    q.push_back(mk("sys_redir",  8'b0001_1010, 6'd8, 32'h0040_0020, HV));
    syscall_req = 1'b1; trap_pc = 32'h0040_0020;
    pulse();
    cycles(3);
    check("sys_in_handler", 64'({exl_o, busy_o, flush_o, redirect_valid}), 64'hC);

    // ERET
    q.push_back(mk("eret_return", 8'b0011_1110, 6'd8, 32'h0040_0020, 32'h0040_0024));
    epc_i = 32'h0040_0024; eret_req = 1'b1;
    pulse();
    cycles(1);
    check("eret_idle", 64'({exl_o, busy_o}), 64'h0);

    // Priority: all three requests together
    q.push_back(mk("prio_commit", 8'b1001_0010, 6'd8, 32'h0040_0100, 32'h0));
    q.push_back(mk("prio_flush1", 8'b0001_0010, 6'd8, 32'h0040_0100, 32'h0));
    q.push_back(mk("prio_redir",  8'b0001_1010, 6'd8, 32'h0040_0100, HV));
    syscall_req = 1'b1; break_req = 1'b1; trap_req = 1'b1;
    trap_cause = 6'd4; trap_pc = 32'h0040_0100;
    pulse();
    cycles(3);

    // Nested fault with simultaneous ERET
    q.push_back(mk("nested_redir", 8'b0001_1111, 6'd8, 32'h0040_0100, HV));
    break_req = 1'b1; eret_req = 1'b1; epc_i = 32'h0040_0abc;
    pulse();
    cycles(1);
    check("nested_stay_handler", 64'({double_fault_o, exl_o, busy_o, flush_o}), 64'hE);

    q.push_back(mk("eret2_return", 8'b0011_1111, 6'd8, 32'h0040_0100, 32'h0040_0104));
    epc_i = 32'h0040_0104; eret_req = 1'b1;
    pulse();
    cycles(1);

    // Spurious ERET in IDLE
    epc_i = 32'h1234_5678; eret_req = 1'b1;
    pulse();
    cycles(1);
    check("spurious_eret_flags", 64'(act_flags()), 64'h01);
    check("spurious_eret_data", {26'h0, cause_o, epc_o}, {26'h0, 6'd8, 32'h0040_0100});

    // Generic trap with code 12
    q.push_back(mk("trap_commit", 8'b0001_0011, 6'd12, 32'h0040_0200, 32'h0));
    q.push_back(mk("trap_flush1", 8'b0001_0011, 6'd12, 32'h0040_0200, 32'h0));
    q.push_back(mk("trap_redir",  8'b0001_1011, 6'd12, 32'h0040_0200, HV));
    trap_req = 1'b1; trap_cause = 6'd12; trap_pc = 32'h0040_0200;
    pulse();
    cycles(3);
    check("trap_in_handler", 64'({exl_o, busy_o}), 64'h3);

    // Leave handler, then reset in the middle of a FLUSH
    q.push_back(mk("eret3_return", 8'b0011_1111, 6'd12, 32'h0040_0200, 32'h0040_0204));
    epc_i = 32'h0040_0204; eret_req = 1'b1;
    pulse();
    cycles(1);

    q.push_back(mk("rst_commit", 8'b1001_0011, 6'd8, 32'h0040_0300, 32'h0));
    syscall_req = 1'b1; trap_pc = 32'h0040_0300;
    pulse();
    cycles(1);
    check("pre_rst_in_flush", 64'({flush_o, busy_o}), 64'h3);
    #1 rst = 1'b0;
    #1;
    check("midflush_rst_flags", 64'(act_flags()), 64'h0);
    check("midflush_rst_data", {cause_o[5:0], epc_o, 26'(redirect_pc[25:0])}, 64'h0);
    cycles(2);
    rst = 1'b1;
    cycles(2);
    check("post_rst_idle", 64'({busy_o, double_fault_o, flush_o}), 64'h0);

    check("scoreboard_drain", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception sequencer between Trap_Detect (MEM-stage trap requests) and the CP0 register block.
- Arbitrates simultaneous trap requests and issues a single-cycle commit pulse to CP0 (EPC/Cause capture).
- Drives the pipeline flush and the PC redirect to the handler vector, tracks the in-handler (EXL) state, and sequences ERET return to the CP0 EPC.

Parameters:
- HANDLER_VEC, 32'h8000_0180, exception handler entry address.
- FLUSH_CYCLES, 2, cycles flush_o is held after commit before redirect (range 1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- syscall_req  in  1  SYSCALL detected in MEM.
- break_req  in  1  BREAK detected in MEM.
- trap_req  in  1  other exception detected in MEM.
- trap_cause  in  6  ExcCode for trap_req.
- trap_pc  in  32  PC of the faulting instruction.
- eret_req  in  1  ERET reached MEM.
- epc_i  in  32  current EPC from CP0.
- syscall_o  out  1  CP0 syscall pulse.
- break_o  out  1  CP0 break pulse.
- cause_o  out  6  CP0 cause input.
- epc_o  out  32  CP0 EPC input.
- eret_o  out  1  CP0 ERET pulse.
- flush_o  out  1  flush IF/ID/EX/MEM.
- redirect_valid  out  1  PC override strobe.
- redirect_pc  out  32  PC override target.
- exl_o  out  1  handler active.
- busy_o  out  1  state != IDLE.
- double_fault_o  out  1  sticky nested-exception flag.

Behaviour:
- States: IDLE, COMMIT, FLUSH, HANDLER, RETURN. All outputs are registered.
- Reset (rst=0, async): state=IDLE, flush counter=0, and every output=0, including double_fault_o. Reset asserted mid-sequence aborts the sequence with no partial pulses.
- Request priority: syscall_req > break_req > trap_req. Code: 8 for syscall, 9 for break, trap_cause for trap_req. Lower-priority requests in the same cycle are dropped.
- IDLE:
  - Any request at edge T latches trap_pc and the code, then moves to COMMIT.
  - eret_req is ignored and produces no outputs.
- COMMIT (exactly 1 cycle):
  - Exactly one of syscall_o/break_o is high for one cycle, or neither when the source was trap_req.
  - cause_o and epc_o hold the latched values.
  - flush_o=1.
  - Moves to FLUSH with counter=FLUSH_CYCLES-1.
- FLUSH:
  - flush_o=1 and the counter decrements each cycle.
  - In the cycle the counter reaches 0: redirect_valid=1 and redirect_pc=HANDLER_VEC for that one cycle, then move to HANDLER.
  - Total flush_o high time = 1+FLUSH_CYCLES cycles. Requests arriving here are ignored (they are being flushed).
- HANDLER:
  - exl_o=1; flush_o=0.
  - eret_req at edge T samples epc_i and moves to RETURN.
  - A syscall/break/trap request here is a nested fault:
    - double_fault_o is set and stays set until reset.
    - No CP0 pulse is issued, so EPC is preserved.
    - Next cycle: flush_o=1 and redirect_valid=1 to HANDLER_VEC, both for one cycle; the block stays in HANDLER.
  - Simultaneous request and eret_req: the nested fault wins and eret_req is dropped.
- RETURN (exactly 1 cycle):
  - eret_o=1, flush_o=1, redirect_valid=1, redirect_pc=the sampled epc_i, exl_o=1.
  - Moves to IDLE, where exl_o=0.
- busy_o=1 in every state except IDLE.
- redirect_pc holds its last value when redirect_valid=0. Consumers qualify it with redirect_valid.

Decomposition:
- Shared package: ExcCode constants (EXC_SYS=6'd8, EXC_BP=6'd9), the state encoding, and the HANDLER_VEC default.
- One sub-module, exc_prio_enc: combinational 3-request priority encoder producing a valid bit and the code.

Test Plan:
- Reset: rst=0 mid-FLUSH with FLUSH_CYCLES=2 -> all outputs 0 immediately; after release, state=IDLE and double_fault_o=0.
- Syscall: syscall_req=1, trap_pc=32'h0040_0020 -> syscall_o=1 with epc_o=32'h0040_0020 and cause_o=8 for 1 cycle; flush_o high 3 cycles; redirect_valid=1 to 32'h8000_0180 on the 3rd; then exl_o=1.
- Priority: syscall_req=break_req=trap_req=1 with trap_cause=6'd4 -> only syscall_o pulses and cause_o=8; break_o never asserts.
- ERET: in HANDLER with epc_i=32'h0040_0024, eret_req=1 -> next cycle eret_o=1, flush_o=1, redirect_valid=1 with redirect_pc=32'h0040_0024; the following cycle exl_o=0 and busy_o=0.
- Nested fault: in HANDLER, break_req and eret_req both high -> double_fault_o=1 (sticky); no break_o or eret_o; one-cycle flush/redirect to 32'h8000_0180; state remains HANDLER.
- Spurious ERET and other code: eret_req in IDLE -> no output change. trap_req with trap_cause=6'd12 -> cause_o=12 and neither syscall_o nor break_o asserted.
